// File: rtl/poly_arb_pkg.sv
// Shared types for the polynomial-evaluator arbiter: FSM state encoding, default width, clog2 helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package poly_arb_pkg;

    localparam int DEF_W = 16;

    typedef enum logic [2:0] {
        st_idle  = 3'd0,
        st_grant = 3'd1,
        st_start = 3'd2,
        st_wait  = 3'd3,
        st_done  = 3'd4
    } state_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/poly_eval_arbiter_if.sv
// Bundle between N requesters, the arbiter and one shared polynomial evaluator.
// Latency: n/a (wires only).
// Backpressure: requesters hold req until gnt; the evaluator has no backpressure (fixed latency).
// slave  : arbiter view (takes req/operands/resultado, drives gnt/done/res_out/busy/ev_*).
// master : requester + evaluator view (the opposite directions).
interface poly_eval_arbiter_if
    import poly_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = DEF_W
);
    logic [N-1:0]   req;
    logic [N*W-1:0] x_in;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N*W-1:0] c_in;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [W-1:0]   res_out;
    logic           busy;
    logic           ev_inicio;
    logic [W-1:0]   ev_x;
    logic [W-1:0]   ev_a;
    logic [W-1:0]   ev_b;
    logic [W-1:0]   ev_c;
    logic [W-1:0]   ev_resultado;

    modport slave (
        input  req, x_in, a_in, b_in, c_in, ev_resultado,
        output gnt, done, res_out, busy, ev_inicio, ev_x, ev_a, ev_b, ev_c
    );

    modport master (
        output req, x_in, a_in, b_in, c_in, ev_resultado,
        input  gnt, done, res_out, busy, ev_inicio, ev_x, ev_a, ev_b, ev_c
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr, wrapping upward.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; any=0 when no request is pending.
// Ports: req (N), ptr (IW) in; onehot (N), idx (IW), any out.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = IW'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/poly_eval_arbiter.sv
// Shares one A*x^2+B*x+C evaluator among N requesters: round-robin grant, operand latch, start pulse, fixed wait, result return.
// Latency: req sampled in IDLE at edge k -> gnt in cycle k+1, done in cycle k+EVAL_LAT+3; one job per EVAL_LAT+4 cycles.
// Backpressure: requesters hold req level until gnt; req is only looked at in IDLE, so losers simply wait.
// Ports: clk, rst (async, active high); bus = poly_eval_arbiter_if.slave (requests/operands/grants/done/result + evaluator side).
module poly_eval_arbiter
    import poly_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = DEF_W,
    parameter int EVAL_LAT = 8
) (
    input  logic                clk,
    input  logic                rst,
    poly_eval_arbiter_if.slave  bus
);

    localparam int IW = (clog2(N) < 1) ? 1 : clog2(N);
    localparam int CW = clog2(EVAL_LAT) + 1;

    state_t        st;
    state_t        st_nx;

    logic [IW-1:0] idx;
    logic [N-1:0]  sel;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [W-1:0]  ev_x_q;
    logic [W-1:0]  ev_a_q;
    logic [W-1:0]  ev_b_q;
    logic [W-1:0]  ev_c_q;
    logic [W-1:0]  res_q;

    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          pick_any;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= st_idle;
        end else begin
            st <= st_nx;
        end
    end

    // Next state plus state-decoded outputs; gnt/done reuse the one-hot winner latched in IDLE.
    always_comb begin
        st_nx         = st;
        bus.gnt       = '0;
        bus.done      = '0;
        bus.busy      = 1'b1;
        bus.ev_inicio = 1'b0;
        case (st)
            st_idle: begin
                bus.busy = 1'b0;
                if (pick_any) begin
                    st_nx = st_grant;
                end
            end
            st_grant: begin
                bus.gnt = sel;
                st_nx   = st_start;
            end
            st_start: begin
                bus.ev_inicio = 1'b1;
                st_nx         = st_wait;
            end
            st_wait: begin
                if (cnt == '0) begin
                    st_nx = st_done;
                end
            end
            st_done: begin
                bus.done = sel;
                st_nx    = st_idle;
            end
            default: begin
                st_nx = st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            sel    <= '0;
            ptr    <= '0;
            cnt    <= '0;
            ev_x_q <= '0;
            ev_a_q <= '0;
            ev_b_q <= '0;
            ev_c_q <= '0;
            res_q  <= '0;
        end else begin
            case (st)
                st_idle: begin
                    if (pick_any) begin
                        idx <= pick_idx;
                        sel <= pick_onehot;
                    end
                end
                st_grant: begin
                    // Operands are frozen here; later changes on the inputs cannot disturb the job.
                    ev_x_q <= bus.x_in[idx*W +: W];
                    ev_a_q <= bus.a_in[idx*W +: W];
                    ev_b_q <= bus.b_in[idx*W +: W];
                    ev_c_q <= bus.c_in[idx*W +: W];
                end
                st_start: begin
                    // Counting EVAL_LAT-1 down to 0 keeps WAIT exactly EVAL_LAT cycles long.
                    cnt <= CW'(EVAL_LAT - 1);
                end
                st_wait: begin
                    if (cnt == '0) begin
                        res_q <= bus.ev_resultado;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                st_done: begin
                    // Winner drops to lowest priority for the next arbitration.
                    ptr <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.ev_x    = ev_x_q;
    assign bus.ev_a    = ev_a_q;
    assign bus.ev_b    = ev_b_q;
    assign bus.ev_c    = ev_c_q;
    assign bus.res_out = res_q;

endmodule

// File: tb/tb_poly_eval_arbiter.sv
// Directed bench for poly_eval_arbiter with a fixed-latency evaluator model and event monitor.
// Latency: evaluator model presents its result EVAL_LAT cycles after the start pulse.
// Backpressure: requesters drop req after seeing their grant unless a test says otherwise.
module tb_poly_eval_arbiter;

    localparam int N        = 4;
    localparam int W        = 16;
    localparam int EVAL_LAT = 8;

    logic clk;
    logic rst;

    poly_eval_arbiter_if #(.N(N), .W(W)) bus ();

    poly_eval_arbiter #(
        .N        (N),
        .W        (W),
        .EVAL_LAT (EVAL_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int gnt_cyc;
    int done_cyc;
    int inicio_cnt;
    int idle_cnt;
    logic [N-1:0] gnt_q[$];
    logic [N-1:0] done_q[$];
    logic [W-1:0] res_q[$];
    logic [W-1:0] ev_v;
    int t0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.gnt != '0) begin
            gnt_q.push_back(bus.gnt);
            gnt_cyc = cyc;
        end
        if (bus.done != '0) begin
            done_q.push_back(bus.done);
            res_q.push_back(bus.res_out);
            done_cyc = cyc;
        end
        if (bus.ev_inicio) inicio_cnt++;
        if (!bus.busy && gnt_q.size() > 0) idle_cnt++;
    end

    // Evaluator: garbage until the result is due, then A*x^2+B*x+C, valid before the capture edge.
    initial begin
        bus.ev_resultado = '0;
        forever begin
            @(negedge clk);
            if (bus.ev_inicio) begin
                ev_v = bus.ev_a * bus.ev_x * bus.ev_x + bus.ev_b * bus.ev_x + bus.ev_c;
                bus.ev_resultado = 16'hdead;
                repeat (EVAL_LAT) @(negedge clk);
                bus.ev_resultado = ev_v;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] x, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] c);
        bus.x_in[i*W +: W] = x;
        bus.a_in[i*W +: W] = a;
        bus.b_in[i*W +: W] = b;
        bus.c_in[i*W +: W] = c;
    endtask

    task automatic clear_logs();
        gnt_q.delete();
        done_q.delete();
        res_q.delete();
        inicio_cnt = 0;
        idle_cnt   = 0;
    endtask

    task automatic wait_gnt(input int budget);
        int n;
        n = 0;
        while (bus.gnt == '0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (bus.gnt == '0) chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int cnt, input int budget);
        int n;
        n = 0;
        while (done_q.size() < cnt && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (done_q.size() < cnt) chk("done_timeout", done_q.size(), cnt);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        bus.req  = '0;
        bus.x_in = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.c_in = '0;
        clear_logs();

        // Reset state
        repeat (3) @(negedge clk); #1;
        chk("rst_gnt",    bus.gnt,       0);
        chk("rst_done",   bus.done,      0);
        chk("rst_busy",   bus.busy,      0);
        chk("rst_inicio", bus.ev_inicio, 0);
        chk("rst_res",    bus.res_out,   0);
        chk("rst_ev_x",   bus.ev_x,      0);
        rst = 1'b0;

        // Single request: 1*2^2 + 2*2 + 2 = 10
        @(negedge clk); #1;
        clear_logs();
        set_ops(0, 2, 1, 2, 2);
        bus.req = 4'b0001;
        t0 = cyc;
        wait_gnt(20);
        bus.req = '0;
        wait_done(1, 40);
        chk("t1_gnt_lat",  gnt_cyc - t0,  1);
        chk("t1_done_lat", done_cyc - t0, 11);
        chk("t1_done",     done_q[0],     4'b0001);
        chk("t1_res",      res_q[0],      10);
        chk("t1_ngnt",     gnt_q.size(),  1);
        chk("t1_ninicio",  inicio_cnt,    1);
        wait_idle();

        // All four requesting from a fresh pointer: x=i+1, A=B=C=1 -> 3,7,13,21
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        clear_logs();
        for (int i = 0; i < N; i++) set_ops(i, 16'(i + 1), 1, 1, 1);
        bus.req = 4'b1111;
        wait_done(5, 5 * (EVAL_LAT + 4) + 20);
        bus.req = '0;
        chk("t2_g0", gnt_q[0], 4'b0001);
        chk("t2_g1", gnt_q[1], 4'b0010);
        chk("t2_g2", gnt_q[2], 4'b0100);
        chk("t2_g3", gnt_q[3], 4'b1000);
        chk("t2_g4", gnt_q[4], 4'b0001);
        chk("t2_r0", res_q[0], 3);
        chk("t2_r1", res_q[1], 7);
        chk("t2_r2", res_q[2], 13);
        chk("t2_r3", res_q[3], 21);
        chk("t2_r4", res_q[4], 3);
        chk("t2_idle_between", idle_cnt, 4);
        wait_idle();

        // Fairness: serve 1 alone (pointer -> 2), then 0 and 1 together -> 0 first
        @(negedge clk); #1;
        clear_logs();
        bus.req = 4'b0010;
        wait_gnt(20);
        bus.req = '0;
        wait_done(1, 40);
        wait_idle();
        bus.req = 4'b0011;
        wait_done(3, 2 * (EVAL_LAT + 4) + 20);
        bus.req = '0;
        chk("t3_g0", gnt_q[0], 4'b0010);
        chk("t3_g1", gnt_q[1], 4'b0001);
        chk("t3_g2", gnt_q[2], 4'b0010);
        wait_idle();

        // Operand change during WAIT must not reach the evaluator
        @(negedge clk); #1;
        clear_logs();
        set_ops(0, 2, 1, 2, 2);
        bus.req = 4'b0001;
        wait_gnt(20);
        bus.req = '0;
        repeat (3) @(negedge clk); #1;
        bus.x_in[0 +: W] = 5;
        @(negedge clk); #1;
        chk("t4_ev_x_wait", bus.ev_x, 2);
        wait_done(1, 40);
        chk("t4_ev_x_done", bus.ev_x, 2);
        chk("t4_res", res_q[0], 10);
        wait_idle();

        // Reset at WAIT count 3 with requester 2 pending
        @(negedge clk); #1;
        clear_logs();
        set_ops(0, 2, 1, 2, 2);
        bus.req = 4'b0001;
        wait_gnt(20);
        bus.req = 4'b0100;
        repeat (6) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_gnt",    bus.gnt,       0);
        chk("t5_done",   bus.done,      0);
        chk("t5_busy",   bus.busy,      0);
        chk("t5_inicio", bus.ev_inicio, 0);
        chk("t5_res",    bus.res_out,   0);
        chk("t5_ev_x",   bus.ev_x,      0);
        repeat (2) @(negedge clk); #1;
        chk("t5_no_done", done_q.size(), 0);
        rst = 1'b0;
        wait_gnt(20);
        chk("t5_gnt_after", bus.gnt, 4'b0100);
        bus.req = '0;
        wait_done(1, 40);
        chk("t5_done_after", done_q[0], 4'b0100);
        chk("t5_res_after",  res_q[0],  13);
        repeat (5) @(negedge clk); #1;
        chk("t5_ndone", done_q.size(), 1);

        // Request pulse from requester 3 only while busy: ignored
        @(negedge clk); #1;
        clear_logs();
        bus.req = 4'b0001;
        wait_gnt(20);
        bus.req = '0;
        repeat (3) @(negedge clk); #1;
        bus.req = 4'b1000;
        repeat (3) @(negedge clk); #1;
        bus.req = '0;
        wait_done(1, 40);
        repeat (20) @(negedge clk); #1;
        chk("t6_ngnt",  gnt_q.size(),  1);
        chk("t6_ndone", done_q.size(), 1);
        chk("t6_done",  done_q[0],     4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
